// File: rtl/ifmap_bank_writer.sv
// Loads the ifmap banks bank-major from a valid/ready stream, then enables the conv controller until it reports done.
// Optional IFMAP_LAST_CHECK_EN: cross-checks s_last against the word count and flags len_err.
module ifmap_bank_writer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned INPUT_NUM_MEM  = 10,
  parameter int unsigned WORDS_PER_BANK = 64,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned BANK_SEL_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_load,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_last,
  output logic [INPUT_NUM_MEM-1:0] wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_en,
  output logic                     conv_enable,
  input  logic                     conv_done,
  output logic                     load_done,
  output logic                     busy,
  output logic                     len_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOAD     = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  localparam logic [1:0] WAIT_CLR = 2'd3;

  localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(WORDS_PER_BANK - 1);
  localparam logic [BANK_SEL_WIDTH-1:0] LAST_BANK = BANK_SEL_WIDTH'(INPUT_NUM_MEM - 1);

  logic [1:0]                state, state_nxt;
  logic [BANK_SEL_WIDTH-1:0] bank, bank_nxt;
  logic [ADDR_WIDTH-1:0]     addr, addr_nxt;
  logic                      conv_done_q;
  logic                      handshake, final_word;

  logic                      s_ready_nxt, rd_en_nxt, conv_enable_nxt, load_done_nxt, busy_nxt;
  logic [INPUT_NUM_MEM-1:0]  wr_en_nxt;
  logic [ADDR_WIDTH-1:0]     wr_addr_nxt;
  logic [DATA_WIDTH-1:0]     wr_data_nxt;

`ifdef IFMAP_LAST_CHECK_EN
  logic len_err_nxt;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign len_err       = 1'b0;
`endif

  assign handshake  = s_valid && s_ready && (state == LOAD);
  assign final_word = (addr == LAST_ADDR) && (bank == LAST_BANK);

  // Next state, counters and next registered outputs
  always_comb begin
    state_nxt     = state;
    bank_nxt      = bank;
    addr_nxt      = addr;
    wr_en_nxt     = '0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    load_done_nxt = 1'b0;
`ifdef IFMAP_LAST_CHECK_EN
    len_err_nxt   = len_err;
`endif

    case (state)
      IDLE: begin
        if (start_load) begin
          state_nxt = LOAD;
          bank_nxt  = '0;
          addr_nxt  = '0;
`ifdef IFMAP_LAST_CHECK_EN
          len_err_nxt = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (handshake) begin
          wr_en_nxt   = INPUT_NUM_MEM'(1) << bank;
          wr_addr_nxt = addr;
          wr_data_nxt = s_data;
          if (final_word) begin
            // Counters park at zero so they never run past the last bank
            bank_nxt      = '0;
            addr_nxt      = '0;
            state_nxt     = RUN;
            load_done_nxt = 1'b1;
`ifdef IFMAP_LAST_CHECK_EN
            if (!s_last) len_err_nxt = 1'b1;
`endif
          end else begin
            if (addr == LAST_ADDR) begin
              addr_nxt = '0;
              bank_nxt = bank + BANK_SEL_WIDTH'(1);
            end else begin
              addr_nxt = addr + ADDR_WIDTH'(1);
            end
`ifdef IFMAP_LAST_CHECK_EN
            if (s_last) begin
              len_err_nxt = 1'b1;
              state_nxt   = IDLE;
            end
`endif
          end
        end
      end
      RUN: begin
        if (conv_done && !conv_done_q) state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        // A done level left high must not retrigger the next image
        if (!conv_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    s_ready_nxt     = (state_nxt == LOAD);
    conv_enable_nxt = (state == RUN) && (state_nxt == RUN);
    rd_en_nxt       = conv_enable_nxt;
    busy_nxt        = (state_nxt != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bank        <= '0;
      addr        <= '0;
      conv_done_q <= 1'b0;
      s_ready     <= 1'b0;
      wr_en       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_en       <= 1'b0;
      conv_enable <= 1'b0;
      load_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bank        <= bank_nxt;
      addr        <= addr_nxt;
      conv_done_q <= conv_done;
      s_ready     <= s_ready_nxt;
      wr_en       <= wr_en_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_data     <= wr_data_nxt;
      rd_en       <= rd_en_nxt;
      conv_enable <= conv_enable_nxt;
      load_done   <= load_done_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef IFMAP_LAST_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) len_err <= 1'b0;
    else       len_err <= len_err_nxt;
  end
`endif

endmodule

// File: doc/ifmap_bank_writer.md
Name: ifmap_bank_writer

Overview:
Fills the input-feature M9K banks that the conv control block later reads, in bank-major order from a valid/ready pixel stream.
Generates per-bank write enables, the shared write address and the write data, and holds read enables low while writing.
After the last word is written it raises conv_enable, which the conv control block uses as its enable, and keeps it high until that block reports conv_done.
Sits between the host/DMA stream and the ifmap memories, ahead of the conv controller.

Parameters:
DATA_WIDTH, 16, pixel word width
INPUT_NUM_MEM, 10, number of ifmap banks written
WORDS_PER_BANK, 64, words written per bank before advancing to the next bank
ADDR_WIDTH, 6, bank address width; must satisfy 2^ADDR_WIDTH >= WORDS_PER_BANK
BANK_SEL_WIDTH, 4, bank index width; must satisfy 2^BANK_SEL_WIDTH >= INPUT_NUM_MEM

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
start_load  in  1  single-cycle pulse that begins a load; honoured only in IDLE
s_valid  in  1  stream word valid
s_ready  out  1  stream ready
s_data  in  DATA_WIDTH  stream pixel
s_last  in  1  marks the final word of the image
wr_en  out  INPUT_NUM_MEM  one-hot per-bank write enable
wr_addr  out  ADDR_WIDTH  write address, shared by all banks
wr_data  out  DATA_WIDTH  write data, shared by all banks
rd_en  out  1  read enable to the banks; 0 in LOAD, 1 in RUN
conv_enable  out  1  enable to the conv controller
conv_done  in  1  level from the conv controller
load_done  out  1  one-cycle pulse when the last word has been written
busy  out  1  high in any state other than IDLE
len_err  out  1  sticky length error; present only with the optional feature

Behaviour:
- Reset (async): every output is 0; state is IDLE; bank and address counters are 0.
- States: IDLE, LOAD, RUN, WAIT_CLR.
- IDLE:
  - s_ready=0.
  - start_load=1 -> LOAD; bank counter and address counter cleared to 0.
- LOAD:
  - s_ready=1.
  - Handshake is s_valid&&s_ready. On a handshake, the next cycle registers wr_en=1<<bank, wr_addr=addr, wr_data=s_data. Write latency is 1 cycle.
  - With no handshake, wr_en=0 the next cycle, and wr_addr/wr_data hold their values.
  - Counter advance on each handshake:
    - addr increments.
    - If addr==WORDS_PER_BANK-1: addr wraps to 0 and bank increments.
    - If additionally bank==INPUT_NUM_MEM-1: this is the final word. s_ready drops the next cycle, state -> RUN, and load_done pulses in the same cycle as the final write.
- RUN:
  - conv_enable=1 and rd_en=1.
  - conv_done rising (0->1, edge detected internally) -> WAIT_CLR; conv_enable drops to 0 the next cycle.
- WAIT_CLR:
  - Wait for conv_done==0, then go to IDLE. This prevents a stale done level from retriggering.
- start_load outside IDLE is ignored. s_valid outside LOAD is ignored; no write occurs.
- Total words per load = INPUT_NUM_MEM*WORDS_PER_BANK. The counters never exceed their final values.
- Reset asserted mid-LOAD or mid-RUN aborts immediately. Partially written banks are not cleared; the next load overwrites them.

Optional Feature:
- Macro IFMAP_LAST_CHECK_EN.
- When defined:
  - len_err is set if s_last=1 on a handshake that is not the final word.
  - len_err is also set if the final word arrives with s_last=0.
  - On an early s_last, the state goes to IDLE without asserting conv_enable or load_done.
  - len_err clears only on reset or on start_load.
- When undefined:
  - s_last is ignored and len_err is tied to 0.
  - Loading ends purely on the word count.

Test Plan:
1. INPUT_NUM_MEM=2, WORDS_PER_BANK=4; start_load, then 8 back-to-back words 0x10..0x17 -> wr_en=01 at addr 0..3 with data 0x10..0x13; wr_en=10 at addr 0..3 with data 0x14..0x17; load_done pulses with the 8th write; conv_enable=1 the next cycle.
2. Same load with s_valid toggled 1,0,1,0 -> wr_en pulses only after handshakes; addresses still run 0..3 per bank without gaps or duplicates.
3. In RUN, drive conv_done 0->1 -> conv_enable=0 one cycle later; hold conv_done=1 for 5 cycles and pulse start_load -> state stays WAIT_CLR; conv_done=0 -> IDLE; a new start_load is then accepted.
4. Assert reset after 5 words -> all outputs 0 immediately; a new load starts at bank 0, addr 0.
5. s_valid=1 and start_load pulses while in RUN -> s_ready=0, no wr_en, state unchanged.
6. With IFMAP_LAST_CHECK_EN defined, s_last on the 3rd word -> len_err=1, state IDLE, conv_enable stays 0; a subsequent start_load clears len_err.
